// File: rtl/mux_nway_rr.sv
// mux_nway_rr: N-channel registered valid/ready mux with directed or round-robin channel choice
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   mode_i                0 = directed by sel_i, 1 = round-robin among valid channels
//   sel_i                 directed-mode channel select; values >= N never grant
//   in_data_i             channel i data at [i*WIDTH +: WIDTH]
//   in_valid_i/in_last_i  per-channel valid and end-of-packet marker
//   in_ready_o            per-channel ready, one-hot or zero, combinational
//   out_data_o/out_chan_o/out_last_o/out_valid_o  registered output beat
//   out_ready_i           consumer ready
// Optional: define MUX_NWAY_PACKET_LOCK_EN to keep a round-robin grant until in_last closes the packet.
module mux_nway_rr #(
  parameter int N = 4,
  parameter int WIDTH = 16,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [N*WIDTH-1:0] in_data_i,
  input  logic [N-1:0]       in_valid_i,
  input  logic [N-1:0]       in_last_i,
  output logic [N-1:0]       in_ready_o,
  output logic [WIDTH-1:0]   out_data_o,
  output logic [SEL_W-1:0]   out_chan_o,
  output logic               out_last_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);
  logic load, xfer, gnt_ok, dir_ok, rr_ok, locked;
  logic [SEL_W-1:0] gnt, rr_gnt, idx, ptr_q, ptr_d, out_chan_q, out_chan_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [WIDTH-1:0] ch_data [N];
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch_data[i] = in_data_i[i*WIDTH +: WIDTH];
    assign in_ready_o[i] = xfer && (gnt == SEL_W'(i));
  end
  // Scan from farthest to nearest so the channel closest after ptr_q wins.
  always_comb begin
    rr_gnt = ptr_q;
    rr_ok = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = SEL_W'((int'(ptr_q) + k) % N);
      if (in_valid_i[idx]) begin
        rr_gnt = idx;
        rr_ok = 1'b1;
      end
    end
  end
  assign dir_ok = (int'(sel_i) < N) ? in_valid_i[sel_i] : 1'b0;
  // While a packet is locked the grant stays on ptr_q, the channel that opened it.
  assign gnt = mode_i ? (locked ? ptr_q : rr_gnt) : sel_i;
  assign gnt_ok = mode_i ? (locked ? in_valid_i[ptr_q] : rr_ok) : dir_ok;
  assign load = !out_valid_q || out_ready_i;
  assign xfer = load && gnt_ok;
  always_comb begin
    out_valid_d = load ? xfer : out_valid_q;
    out_data_d = xfer ? ch_data[gnt] : out_data_q;
    out_chan_d = xfer ? gnt : out_chan_q;
    out_last_d = xfer ? in_last_i[gnt] : out_last_q;
    ptr_d = (xfer && mode_i) ? gnt : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      out_last_q <= 1'b0;
      ptr_q <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      out_last_q <= out_last_d;
      ptr_q <= ptr_d;
    end
  end
`ifdef MUX_NWAY_PACKET_LOCK_EN
  logic lock_q, lock_d;
  assign lock_d = !mode_i ? 1'b0 : xfer ? !in_last_i[gnt] : lock_q;
  assign locked = lock_q && mode_i;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else lock_q <= lock_d;
  end
`else
  assign locked = 1'b0;
`endif
  assign out_valid_o = out_valid_q;
  assign out_data_o = out_data_q;
  assign out_chan_o = out_chan_q;
  assign out_last_o = out_last_q;
endmodule

// File: tb/tb_mux_nway_rr.sv
// tb_mux_nway_rr: scoreboard bench for mux_nway_rr (N=4 main instance, N=5 for out-of-range select)
module tb_mux_nway_rr;
  localparam int N = 4;
  localparam int W = 16;
  localparam int SW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode, out_last, out_valid, out_ready;
  logic [SW-1:0] sel, out_chan;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid, in_last, in_ready;
  logic [W-1:0] out_data;
  logic b_mode, b_olast, b_ovalid, b_oready;
  logic [2:0] b_sel, b_chan;
  logic [5*W-1:0] b_data;
  logic [4:0] b_valid, b_last, b_ready;
  logic [W-1:0] b_odata;
  int total = 0;
  int bad = 0;
  typedef struct packed {
    logic [W-1:0] data;
    logic [SW-1:0] chan;
    logic last;
  } beat_t;
  beat_t sb[$];
  int m_ptr;
  logic m_lock, m_ov;

  mux_nway_rr #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .sel_i(sel),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_chan_o(out_chan), .out_last_o(out_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  mux_nway_rr #(.N(5), .WIDTH(W)) dut5 (
    .clk(clk), .rst_n(rst_n), .mode_i(b_mode), .sel_i(b_sel),
    .in_data_i(b_data), .in_valid_i(b_valid), .in_last_i(b_last), .in_ready_o(b_ready),
    .out_data_o(b_odata), .out_chan_o(b_chan), .out_last_o(b_olast),
    .out_valid_o(b_ovalid), .out_ready_i(b_oready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 16'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Reference model: evaluates the grant for the coming edge from the current inputs.
  always @(negedge clk) begin
    int g;
    logic ok, ld, xf;
    beat_t e;
    if (!rst_n) begin
      m_ptr = N - 1;
      m_lock = 1'b0;
      m_ov = 1'b0;
      sb.delete();
    end else begin
      chk("out_valid", out_valid, m_ov);
      if (m_ov && sb.size() == 0) chk("sb_depth", sb.size(), 1);
      else if (m_ov) begin
        e = sb[0];
        chk("out_data", out_data, e.data);
        chk("out_chan", out_chan, e.chan);
        chk("out_last", out_last, e.last);
        if (out_ready) void'(sb.pop_front());
      end
      g = 0;
      ok = 1'b0;
      if (!mode) begin
        g = int'(sel);
        ok = in_valid[sel];
      end else if (m_lock) begin
        g = m_ptr;
        ok = in_valid[g];
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (!ok && in_valid[(m_ptr + k) % N]) begin
            g = (m_ptr + k) % N;
            ok = 1'b1;
          end
        end
      end
      ld = !m_ov || out_ready;
      xf = ld && ok;
      chk("in_ready", in_ready, xf ? (64'd1 << g) : 64'd0);
      if (xf) begin
        e.data = in_data[g*W +: W];
        e.chan = SW'(g);
        e.last = in_last[g];
        sb.push_back(e);
      end
      if (ld) m_ov = xf;
      if (xf && mode) m_ptr = g;
`ifdef MUX_NWAY_PACKET_LOCK_EN
      if (!mode) m_lock = 1'b0;
      else if (xf) m_lock = !in_last[g];
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_all[6];
    int exp_alt[4];
    int exp_pk[9];
    int c2;
    logic [W-1:0] d0;
    exp_all = '{0, 1, 2, 3, 0, 1};
    exp_alt = '{1, 3, 1, 3};
`ifdef MUX_NWAY_PACKET_LOCK_EN
    exp_pk = '{2, 2, 2, 3, 0, 1, 3, 0, 1};
`else
    exp_pk = '{2, 3, 0, 1, 2, 3, 0, 1, 2};
`endif
    mode = 1'b0; sel = '0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;
    b_mode = 1'b0; b_sel = '0; b_data = '0; b_valid = '0; b_last = '0; b_oready = 1'b1;
    repeat (2) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_last", out_last, 0);
    chk("rst_valid5", b_ovalid, 0);
    rst_n = 1'b1;
    // directed sweep
    in_valid = 4'hF;
    for (int i = 0; i < 1000; i++) begin
      rnd_data();
      sel = SW'($urandom);
      in_last = 4'($urandom);
      step();
    end
    in_valid = '0;
    step();
    // round-robin fairness from reset
    do_reset();
    mode = 1'b1;
    in_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      rnd_data();
      step();
      chk("rr_all", out_chan, exp_all[i]);
    end
    do_reset();
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      rnd_data();
      step();
      chk("rr_1010", out_chan, exp_alt[i]);
    end
    // backpressure
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF;
    rnd_data();
    d0 = in_data[2*W +: W];
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rnd_data();
      #1;
      chk("bp_ready", in_ready, 0);
      step();
      chk("bp_data", out_data, d0);
      chk("bp_chan", out_chan, 2);
    end
    out_ready = 1'b1;
    d0 = in_data[2*W +: W];
    #1;
    chk("bp_release", in_ready, 4'b0100);
    step();
    chk("bp_next", out_data, d0);
    in_valid = '0;
    step();
    // out-of-range select on the N=5 instance
    b_valid = 5'h1F;
    b_data = {$urandom, $urandom, 16'($urandom)};
    b_sel = 3'd1;
    d0 = b_data[W +: W];
    step();
    chk("n5_valid", b_ovalid, 1);
    chk("n5_chan", b_chan, 1);
    chk("n5_data", b_odata, d0);
    b_sel = 3'd7;
    #1;
    chk("n5_sel7_ready", b_ready, 0);
    step();
    chk("n5_sel7_valid", b_ovalid, 0);
    // idle round-robin drains the output
    mode = 1'b1; in_valid = 4'hF;
    step();
    chk("idle_pre", out_valid, 1);
    in_valid = '0;
    step();
    chk("idle_valid", out_valid, 0);
    // asynchronous reset while a beat is held
    in_valid = 4'hF;
    rnd_data();
    step();
    chk("arst_pre", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("arst_first", out_chan, 0);
    // packet on ch2 among competing channels
    do_reset();
    mode = 1'b1; in_valid = 4'b0010; in_last = 4'hF;
    step();
    c2 = 0;
    for (int i = 0; i < 9; i++) begin
      in_valid = {1'b1, c2 < 3, 1'b1, 1'b1};
      in_last[2] = (c2 == 2);
      rnd_data();
      step();
      chk("pkt_seq", out_chan, exp_pk[i]);
      if (exp_pk[i] == 2) c2++;
    end
    // random traffic with backpressure and mode changes
    for (int i = 0; i < 400; i++) begin
      rnd_data();
      mode = 1'($urandom);
      sel = SW'($urandom);
      in_valid = 4'($urandom);
      in_last = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = '0;
    out_ready = 1'b1;
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux_nway_rr.md
Name: mux_nway_rr

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes on every input channel and on the output.
- Next generation of the combinational Mux4Way16/Mux8Way16 parts.
- Two modes:
  - Directed: the `sel` port picks the channel.
  - Round-robin: the block arbitrates fairly among valid channels.
- Sits between multiple producers (e.g. memory-mapped peripherals, CPU write port) and a single consumer bus in the Hack FPGA fabric.

Parameters:
- N, 4, number of input channels (N >= 2).
- WIDTH, 16, data width per channel.
- SEL_W, $clog2(N), width of `sel` and `out_chan` (minimum 1).

Ports:
- clk, input, 1, system clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- mode, input, 1, 0 = directed by `sel`, 1 = round-robin.
- sel, input, SEL_W, channel select in directed mode.
- in_data, input, N*WIDTH, channel i at [i*WIDTH +: WIDTH].
- in_valid, input, N, per-channel valid.
- in_last, input, N, per-channel end-of-packet marker.
- in_ready, output, N, per-channel ready (combinational).
- out_data, output, WIDTH, registered selected data.
- out_chan, output, SEL_W, registered index of the channel that produced `out_data`.
- out_last, output, 1, registered copy of `in_last` of the granted channel.
- out_valid, output, 1, registered output valid.
- out_ready, input, 1, consumer ready.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - `out_valid`, `out_data`, `out_chan` and `out_last` = 0.
  - Round-robin pointer `ptr` = N-1, so channel 0 has first priority.
  - Lock flag = 0.
- Load enable: `load` = !out_valid || out_ready. The output register never drops or duplicates a beat.
- Grant (combinational), directed mode:
  - `gnt` = sel; `gnt_ok` = (sel < N) && in_valid[sel].
  - sel >= N never grants.
- Grant (combinational), round-robin mode:
  - Scan channels ptr+1, ptr+2, … modulo N; the first with in_valid=1 wins.
  - `gnt_ok` = |in_valid.
- in_ready[i] = load && gnt_ok && (gnt == i). At most one bit is high. `in_ready` never depends on `in_valid[i]` of a non-granted channel.
- Transfer: in_valid[gnt] && in_ready[gnt]. On the next edge:
  - out_data <= in_data[gnt]; out_chan <= gnt; out_last <= in_last[gnt]; out_valid <= 1.
  - In round-robin mode, ptr <= gnt.
- Idle load: if `load` = 1 and no transfer, out_valid <= 0 and `out_data`/`out_chan`/`out_last` hold.
- Stall: out_valid=1 && out_ready=0 → every in_ready = 0 and all output registers hold.
- Latency and throughput: 1 cycle input-to-output; 1 beat/cycle sustained when out_ready is held at 1.
- Fairness: with all N channels continuously valid in round-robin mode, grants cycle 0,1,…,N-1,0,…; no channel waits more than N-1 transfers.
- Mode change: takes effect in the same cycle's grant computation. `ptr` is preserved across directed-mode operation.
- Async reset mid-transfer: the beat in the output register is discarded; producers must re-present it.

Optional Feature:
- Macro: MUX_NWAY_PACKET_LOCK_EN.
- With the macro defined, in round-robin mode:
  - A transfer with in_last[gnt]=0 sets the lock and holds the grant on that channel.
  - While locked, no other channel is granted, even if the locked channel drops in_valid.
  - A transfer with in_last=1 clears the lock, and arbitration resumes from ptr = that channel.
  - Any cycle with mode=0 clears the lock.
- Without the macro: no lock; every beat is arbitrated independently. in_last is only passed through to out_last.

Test Plan:
- Directed sweep: N=4, WIDTH=16, mode=0, random in_data, in_valid=4'b1111, sel=0..3, out_ready=1 → out_data equals channel sel one cycle later, out_chan=sel; repeat 1000 random vectors.
- Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1 from reset → out_chan sequence 0,1,2,3,0,1 on consecutive cycles. in_valid=4'b1010 → sequence 1,3,1,3.
- Backpressure: out_valid=1 with out_ready=0 for 5 cycles → in_ready=0, out_data/out_chan stable. Then out_ready=1 → next beat in the same cycle; no lost or duplicated data against the scoreboard.
- Boundary: N=5, mode=0, sel=7 → in_ready=0 and out_valid falls to 0. All in_valid=0 in mode 1 → out_valid=0 after one cycle.
- Reset mid-stream: assert rst_n=0 asynchronously between edges while out_valid=1 → out_valid=0 immediately. After release, channel 0 is granted first.
- Packet lock (macro defined): ch2 sends 3 beats with in_last=0,0,1 while ch0/ch1/ch3 are valid → out_chan=2,2,2, then 3,0,1. Without the macro, the same stimulus → 0,1,2,3 interleaved.
